// File: rtl/systolic_pkg.sv
// Shared types for the systolic array output path.
// The array geometry and the psum width are fixed here so every stage agrees on them.
package systolic_pkg;
  localparam int SA_N   = 16;
  localparam int PSUM_W = 32;

  typedef logic [PSUM_W-1:0] psum_t;
  typedef psum_t psum_vec_t [SA_N-1:0];
endpackage

// File: rtl/systolic_output_deskew_if.sv
// Valid/ready link that carries aligned row vectors to the accumulator/writeback stage.
interface systolic_output_deskew_if;
  import systolic_pkg::*;

  psum_vec_t out_data;
  logic      out_valid;
  logic      out_ready;
  logic      out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/psum_vec_fifo.sv
// Synchronous FIFO of whole psum row vectors; head entry is read straight from storage.
// Pointers carry one extra bit so full and empty stay distinguishable.
module psum_vec_fifo
  import systolic_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  psum_vec_t     din,
  output psum_vec_t     dout,
  output logic [PW-1:0] count,
  output logic          full,
  output logic          empty
);

  psum_vec_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Push while full is legal when a pop happens in the same cycle: the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/systolic_output_deskew.sv
// Realigns the column-staggered bottom-row psums of the systolic array into full row vectors
// and buffers them for the writeback stage; the array cannot stall, so overflow is only flagged.
module systolic_output_deskew
  import systolic_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  psum_vec_t                sys_output,
  input  logic [SA_N-1:0]          sys_valid_out,
  systolic_output_deskew_if.master wb,
  output logic [CW-1:0]            fifo_count,
  output logic                     overflow,
  output logic                     align_err
);

  localparam int              RW       = $clog2(SA_N);
  localparam logic [RW-1:0]   ROW_LAST = RW'(SA_N - 1);

  psum_vec_t       dly_data;
  psum_vec_t       fifo_dout;
  logic [SA_N-1:0] dly_valid;
  logic            aligned_valid;
  logic            skew;
  logic            push;
  logic            pop;
  logic            drop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [RW-1:0]   row_cnt;

  // Column j sees SA_N-j stages so every element of a row lines up with column 0.
  for (genvar j = 0; j < SA_N; j++) begin : g_col
    localparam int STAGES = SA_N - j;
    psum_t             d_pipe [STAGES];
    logic [STAGES-1:0] v_pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_pipe <= '0;
        for (int s = 0; s < STAGES; s++) d_pipe[s] <= '0;
      end else begin
        d_pipe[0] <= sys_output[j];
        v_pipe[0] <= sys_valid_out[j];
        for (int s = 1; s < STAGES; s++) begin
          d_pipe[s] <= d_pipe[s-1];
          v_pipe[s] <= v_pipe[s-1];
        end
      end
    end

    assign dly_data[j]  = d_pipe[STAGES-1];
    assign dly_valid[j] = v_pipe[STAGES-1];
  end

  assign aligned_valid = dly_valid[0];
  assign skew          = |(dly_valid ^ {SA_N{aligned_valid}});

  assign pop  = wb.out_valid && wb.out_ready;
  assign push = aligned_valid && (!fifo_full || pop);
  assign drop = aligned_valid && fifo_full && !pop;

  psum_vec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (dly_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt   <= '0;
      overflow  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      if (pop)  row_cnt   <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      if (drop) overflow  <= 1'b1;
      if (skew) align_err <= 1'b1;
    end
  end

  // Storage is not reset, so the head is masked to zero whenever nothing valid is buffered.
  always_comb begin
    for (int j = 0; j < SA_N; j++) begin
      wb.out_data[j] = fifo_empty ? '0 : fifo_dout[j];
    end
  end

  assign wb.out_valid = !fifo_empty;
  assign wb.out_last  = wb.out_valid && (row_cnt == ROW_LAST);

endmodule
